// File: rtl/wb_framebuf_pingpong.sv
// Ping-pong frame buffer: byte-wide writes go to the back bank, word-wide reads
// come from the front bank. A bank swap is taken only at a frame boundary, and a
// clear engine can fill the back bank with a constant value.
module wb_framebuf_pingpong #(
  parameter int          RD_AW     = 9,
  parameter int          LANE_BITS = 2,
  parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [RD_AW+LANE_BITS-1:0] wr_addr_i,
  input  logic [7:0]                 wr_data_i,
  input  logic                       rd_en_i,
  input  logic [RD_AW-1:0]           rd_addr_i,
  output logic [(8<<LANE_BITS)-1:0]  rd_data_o,
  output logic                       rd_valid_o,
  input  logic                       frame_end_i,
  input  logic                       swap_req_i,
  output logic                       swap_pending_o,
  output logic                       front_bank_o,
  input  logic                       clear_req_i,
  output logic                       busy_o
);

  localparam int NUM_LANES = 1 << LANE_BITS;
  localparam int DEPTH     = 1 << RD_AW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_n;
  logic [RD_AW:0]   cnt, cnt_n, cnt_inc;
  logic             swap_take;
  logic             back_bank;
  logic [RD_AW:0]   waddr, raddr;
  logic [7:0]       wdata;
  logic [LANE_BITS-1:0] wr_lane;
  logic [NUM_LANES-1:0][7:0] rd_q;

  assign busy_o    = (state == CLEAR);
  assign back_bank = ~front_bank_o;
  assign wr_lane   = wr_addr_i[LANE_BITS-1:0];
  assign swap_take = (swap_pending_o || swap_req_i) && frame_end_i && !busy_o;
  // Extra counter bit flags the terminal word without comparing against a wrapped value.
  assign cnt_inc   = cnt + 1'b1;

  // Clear engine owns the back-bank write port while busy; otherwise the CPU does.
  assign waddr = busy_o ? {back_bank, cnt[RD_AW-1:0]}
                        : {back_bank, wr_addr_i[RD_AW+LANE_BITS-1:LANE_BITS]};
  assign wdata = busy_o ? CLEAR_VAL : wr_data_i;
  assign raddr = {front_bank_o, rd_addr_i};

  // Clear FSM next-state: one word per cycle, back to IDLE after the last word.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (clear_req_i) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        cnt_n = cnt_inc;
        if (cnt_inc[RD_AW]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, swap-pending and front-bank registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      front_bank_o   <= 1'b0;
      swap_pending_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (swap_take) begin
        front_bank_o   <= ~front_bank_o;
        swap_pending_o <= 1'b0;
      end else if (swap_req_i) begin
        swap_pending_o <= 1'b1;
      end
    end
  end

  // Read valid follows the read strobe by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_valid_o <= 1'b0;
    else       rd_valid_o <= rd_en_i;
  end

  assign rd_data_o = rd_q;

  // One byte-wide RAM per lane, holding both banks (bank bit is the address MSB).
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [2*DEPTH] = '{default: CLEAR_VAL};
    logic [7:0] q;
    logic       we;

    assign we      = busy_o || (wr_en_i && (wr_lane == LANE_BITS'(l)));
    assign rd_q[l] = q;

    // Lane write: every lane during clear, addressed lane for CPU writes.
    always_ff @(posedge clk_i) begin
      if (we) mem[waddr] <= wdata;
    end

    // Lane read: registered, holds its value while no read is issued.
    always_ff @(posedge clk_i) begin
      if (rst_i)        q <= '0;
      else if (rd_en_i) q <= mem[raddr];
    end
  end

endmodule
